thermal_tx_framer: RTL and testbench

- Upstream modulation stage for the thermal covert-channel transmitter.
- Accepts a data byte through a valid/ready handshake and serialises it into a timed heater-enable bit stream: preamble, data MSB-first, even parity, then a mandatory cool-down guard.
- heat_en directly gates the ring-oscillator heater block. heat_en=1 means the oscillator toggles and the die heats; heat_en=0 means it idles.

---
 rtl/thermal_tx_framer.sv | 133 +++++++++++++
 tb/tb_thermal_tx_framer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/thermal_tx_framer.sv
// thermal_tx_framer: serialises a byte into a timed preamble/data/parity heater bit stream with cool-down guard
module thermal_tx_framer #(
  parameter int BIT_CYCLES = 100000000,
  parameter int DATA_W = 8,
  parameter int PRE_LEN = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 4'b1010,
  parameter int GUARD_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              tx_abort,
  output logic              heat_en,
  output logic              busy,
  output logic              frame_done,
  output logic              aborted
);
  localparam int TW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int ML0 = PRE_LEN > DATA_W ? PRE_LEN : DATA_W;
  localparam int ML = ML0 > GUARD_BITS ? ML0 : GUARD_BITS;
  localparam int IW = ML > 1 ? $clog2(ML) : 1;
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GUARD} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PRE_LEN-1:0] pre_q, pre_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic par_q, par_d, heat_q, heat_d, done_q, done_d, abt_q, abt_d, flag_q, flag_d;
  logic wrap, sending;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pre_d = pre_q;
    data_d = data_q;
    par_d = par_q;
    heat_d = heat_q;
    flag_d = flag_q;
    done_d = 1'b0;
    abt_d = 1'b0;
    wrap = timer_q == TW'(BIT_CYCLES - 1);
    sending = state_q == PRE || state_q == DATA || state_q == PAR;
    timer_d = (state_q == IDLE || wrap) ? '0 : timer_q + TW'(1);
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = PRE;
        heat_d = PREAMBLE[PRE_LEN-1];
        pre_d = PREAMBLE << 1;
        data_d = tx_data;
        par_d = ^tx_data;
        idx_d = '0;
        flag_d = 1'b0;
      end
      PRE: if (wrap) begin
        if (idx_q == IW'(PRE_LEN - 1)) begin
          state_d = DATA;
          heat_d = data_q[DATA_W-1];
          data_d = data_q << 1;
          idx_d = '0;
        end else begin
          heat_d = pre_q[PRE_LEN-1];
          pre_d = pre_q << 1;
          idx_d = idx_q + IW'(1);
        end
      end
      DATA: if (wrap) begin
        if (idx_q == IW'(DATA_W - 1)) begin
          state_d = PAR;
          heat_d = par_q;
          idx_d = '0;
        end else begin
          heat_d = data_q[DATA_W-1];
          data_d = data_q << 1;
          idx_d = idx_q + IW'(1);
        end
      end
      PAR: if (wrap) begin
        state_d = GUARD;
        heat_d = 1'b0;
        idx_d = '0;
      end
      GUARD: if (wrap) begin
        if (idx_q == IW'(GUARD_BITS - 1)) begin
          state_d = IDLE;
          done_d = 1'b1;
          abt_d = flag_q;
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (tx_abort && sending) begin
      state_d = GUARD;
      heat_d = 1'b0;
      timer_d = '0;
      idx_d = '0;
      flag_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q <= '0;
      pre_q <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      heat_q <= 1'b0;
      done_q <= 1'b0;
      abt_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      pre_q <= pre_d;
      data_q <= data_d;
      par_q <= par_d;
      heat_q <= heat_d;
      done_q <= done_d;
      abt_q <= abt_d;
      flag_q <= flag_d;
    end
  end
  assign tx_ready = state_q == IDLE || !reset;
  assign busy = state_q != IDLE;
  assign heat_en = heat_q;
  assign frame_done = done_q;
  assign aborted = abt_q;
endmodule

// File: tb/tb_thermal_tx_framer.sv
// tb_thermal_tx_framer: scoreboard bench checking heater bit traces, frame timing and abort/reset handling
module tb_thermal_tx_framer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_abort = 1'b0;
  logic tx_ready, heat_en, busy, frame_done, aborted;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [63:0] tr;
    int len;
    bit ab;
  } exp_t;
  exp_t sb[$];
  thermal_tx_framer #(
    .BIT_CYCLES(4),
    .DATA_W(8),
    .PRE_LEN(4),
    .PREAMBLE(4'b1010),
    .GUARD_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_abort(tx_abort),
    .heat_en(heat_en),
    .busy(busy),
    .frame_done(frame_done),
    .aborted(aborted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic exp_t mk(input logic [12:0] b, input int n, input bit ab);
    exp_t e;
    e.tr = '0;
    for (int i = 0; i < n; i++) e.tr[i] = b[12 - i / 4];
    e.len = n + 8;
    e.ab = ab;
    return e;
  endfunction
  initial begin
    logic [63:0] tr;
    int cnt;
    exp_t e;
    tr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        tr = '0;
        cnt = 0;
      end else begin
        if (busy) begin
          if (cnt < 64) tr[cnt] = heat_en;
          cnt++;
        end
        if (frame_done) begin
          if (sb.size() == 0) chk("spurious_frame_done", frame_done, 0);
          else begin
            e = sb.pop_front();
            chk("frame_len", cnt, e.len);
            chk("frame_bits", tr, e.tr);
            chk("frame_aborted", aborted, e.ab);
          end
          tr = '0;
          cnt = 0;
        end else if (aborted) chk("stray_aborted", aborted, 0);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    tx_valid = 1'b1;
    tx_data = 8'hC5;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_heat", heat_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_done", frame_done, 0);
    end
    reset = 1'b1;
    sb.push_back(mk(13'b1010_11000101_0, 52, 0));
    step(1);
    tx_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", tx_ready, 0);
    chk("first_bit", heat_en, 1);
    step(59);
    chk("c60_ready", tx_ready, 0);
    chk("c60_done", frame_done, 0);
    step(1);
    chk("c61_done", frame_done, 1);
    chk("c61_ready", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data = 8'h01;
    sb.push_back(mk(13'b1010_00000001_1, 52, 0));
    step(1);
    tx_valid = 1'b0;
    step(48);
    chk("odd_parity_bit", heat_en, 1);
    step(12);
    chk("odd_c61_done", frame_done, 1);
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    sb.push_back(mk(13'b1010_11111111_0, 52, 0));
    sb.push_back(mk(13'b1010_00000000_0, 52, 0));
    step(1);
    tx_data = 8'h00;
    step(60);
    chk("b2b_done", frame_done, 1);
    chk("b2b_ready", tx_ready, 1);
    step(1);
    tx_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_pre", heat_en, 1);
    step(60);
    chk("b2b2_done", frame_done, 1);
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    sb.push_back(mk(13'b1010_11111111_0, 20, 1));
    step(1);
    tx_valid = 1'b0;
    step(19);
    tx_abort = 1'b1;
    step(1);
    tx_abort = 1'b0;
    chk("abort_heat", heat_en, 0);
    step(3);
    tx_abort = 1'b1;
    step(1);
    tx_abort = 1'b0;
    step(3);
    chk("abort_c28_done", frame_done, 0);
    step(1);
    chk("abort_c29_done", frame_done, 1);
    chk("abort_c29_aborted", aborted, 1);
    tx_valid = 1'b1;
    tx_data = 8'hC5;
    step(1);
    tx_valid = 1'b0;
    step(29);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("midrst_heat", heat_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_done", frame_done, 0);
    step(70);
    chk("midrst_idle", busy, 0);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
